fetch_decode_queue: RTL
=======================

# fetch_decode_queue

Buffers instruction words between the fetch stage and DecodeUnit. It stamps each accepted word with a unique, monotonically increasing major instruction ID and presents words in program order on a registered output. The output drives DecodeUnit's `enable_i`/`instruction_i`/`instructionMajId_i` inputs directly. Decode back-pressure (`stall_i`) and pipeline flush are absorbed here, so fetch only has to observe `full_o`.

## Interface
Reset is asynchronous and active-low. All other behaviour is synchronous to the `clock_i` rising edge.

Parameters:
- addressWidth, 64, instruction address width
- instructionWidth, 32, instruction word width
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID width
- queueDepth, 8, storage entries; power of two, ≥2

Ports:
- clock_i  in  1  clock
- reset_i  in  1  asynchronous reset, active-low
- enable_i  in  1  fetch presents a word this cycle
- instruction_i  in  instructionWidth  instruction word
- instructionAddress_i  in  addressWidth  word address
- is64Bit_i  in  1  64-bit mode flag
- instructionPid_i  in  PidSize  process ID
- instructionTid_i  in  TidSize  thread ID
- flush_i  in  1  discard all buffered and presented words
- stall_i  in  1  decode cannot accept the output this cycle
- full_o  out  1  storage holds queueDepth entries
- count_o  out  $clog2(queueDepth)+1  entries currently in storage
- overflow_o  out  1  sticky: a push was dropped because the queue was full
- enable_o  out  1  output word valid
- instruction_o, instructionAddress_o, is64Bit_o, instructionPid_o, instructionTid_o  out  (widths as inputs)  presented word
- instructionMajId_o  out  instructionCounterWidth  major ID of presented word

## Operation
- **Storage:** circular buffer of queueDepth entries with read/write pointers of $clog2(queueDepth) bits that wrap naturally. An output register follows the buffer, so total capacity is queueDepth+1.
- **Push:** when enable_i && !full_o && !flush_i, the entry {word, address, is64Bit, pid, tid, majIdCtr} is written and majIdCtr increments.
  - majIdCtr wraps from 2^instructionCounterWidth−1 to 0.
  - enable_i && full_o drops the word, leaves majIdCtr unchanged and sets overflow_o. overflow_o clears only on reset.
- **Advance:** the output register loads the buffer head when storage is non-empty and (!enable_o || !stall_i).
  - Storage empty and output consumed (enable_o && !stall_i): enable_o falls.
  - stall_i with enable_o high: all outputs hold unchanged.
- **Simultaneous push and advance:** count_o unchanged, both pointers step.
  - full_o is derived from the registered count, so a push in a cycle where full_o=1 is refused even if an advance also happens that cycle.
- **Flush (highest priority):** pointers and count go to 0 and enable_o goes to 0 at the next edge. Any push in that cycle is ignored. majIdCtr is not rewound, so IDs stay unique across flushes.
- **No bypass:** an empty queue never forwards the input combinationally to the output.

## Timing
- **Reset values:** all outputs 0, including enable_o, count_o, full_o, overflow_o and all data outputs. Pointers and majIdCtr are 0.
- **Latency:** a word pushed at edge N into an empty queue with an empty or consumed output register has enable_o=1 after edge N+1.
- **Throughput:** one word per cycle sustained when stall_i=0.
- **Output stability:** a word is consumed by decode on an edge where enable_o && !stall_i.
- **Flags:** full_o and count_o are registered-state decodes and update after the causing edge.
- **Reset mid-operation:** all state is lost immediately (asynchronous). Normal operation resumes on the first edge after reset_i deasserts.

## Structure
- Shared package `fetch_pkg`:
  - the queue entry struct/width constant (instruction+address+is64Bit+pid+tid+majId)
  - default widths matching DecodeUnit
- Storage is a natural sub-module `fetch_queue_ram`: a queueDepth × entry-width register array with one write port and one asynchronous read port.
- Pointer, count and output-register control stay in the top module.

## Test plan
- **Reset:** drive reset_i=0 mid-stream with 5 entries stored -> all outputs 0, count_o=0. After release, the first push gets majId 0.
- **Latency and ordering:** push addresses 0x0, 0x4, 0x8 on consecutive cycles with stall_i=0 -> enable_o rises one edge after the first push; the presented majIds are 0, 1, 2 in order; enable_o falls after the third word is consumed.
- **Full and overflow:** stall_i=1, push 10 words with queueDepth=8.
  - Expect: first word held in the output register; full_o=1 after 9 accepted pushes; 10th word dropped and overflow_o=1; majIdCtr=9.
  - Release stall -> words with majIds 0..8 emerge in order.
- **Stall hold:** assert stall_i for 3 cycles while enable_o=1 -> all outputs bit-identical across those cycles, and the next word appears one edge after stall_i drops.
- **Flush:** with 4 stored words plus 1 presented, assert flush_i together with a push.
  - Expect: next edge gives enable_o=0, count_o=0, and the pushed word is absent.
  - The following push gets majId 5, not 0.
- **Wrap-around:** preload majIdCtr via a bench force to 2^64−2, push 3 words -> majIds 2^64−2, 2^64−1, 0. Cycle 20 words through to exercise pointer wrap -> order preserved.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-to-decode path: default widths matching DecodeUnit
// and the layout of one buffered queue entry.
package fetch_pkg;

    localparam int defAddressWidth            = 64;
    localparam int defInstructionWidth        = 32;
    localparam int defPidSize                 = 20;
    localparam int defTidSize                 = 16;
    localparam int defInstructionCounterWidth = 64;
    localparam int defQueueDepth              = 8;

    // Field order matches the packed storage word, majId in the top bits.
    typedef struct packed {
        logic [defInstructionCounterWidth-1:0] majId;
        logic [defTidSize-1:0]                 tid;
        logic [defPidSize-1:0]                 pid;
        logic                                  is64Bit;
        logic [defAddressWidth-1:0]            address;
        logic [defInstructionWidth-1:0]        instruction;
    } queueEntry_t;

    localparam int queueEntryWidth = $bits(queueEntry_t);

    function automatic int entryWidth(input int addrW, input int instrW, input int pidW,
                                      input int tidW, input int ctrW);
        return addrW + instrW + 1 + pidW + tidW + ctrW;
    endfunction

endpackage

// File: rtl/fetch_decode_queue_if.sv
// Bundle between fetch/decode and the queue. The queue side uses the slave modport.
interface fetch_decode_queue_if
    import fetch_pkg::*;
#(
    parameter int addressWidth            = defAddressWidth,
    parameter int instructionWidth        = defInstructionWidth,
    parameter int PidSize                 = defPidSize,
    parameter int TidSize                 = defTidSize,
    parameter int instructionCounterWidth = defInstructionCounterWidth,
    parameter int queueDepth              = defQueueDepth
) ();

    // Handshake: enable_o is valid, !stall_i is ready; a word transfers on an edge where
    // both hold. enable_i is an unacknowledged push that fetch must gate with full_o.
    logic                               enable_i;
    logic [instructionWidth-1:0]        instruction_i;
    logic [addressWidth-1:0]            instructionAddress_i;
    logic                               is64Bit_i;
    logic [PidSize-1:0]                 instructionPid_i;
    logic [TidSize-1:0]                 instructionTid_i;
    logic                               flush_i;
    logic                               stall_i;

    logic                               full_o;
    logic [$clog2(queueDepth):0]        count_o;
    logic                               overflow_o;
    logic                               enable_o;
    logic [instructionWidth-1:0]        instruction_o;
    logic [addressWidth-1:0]            instructionAddress_o;
    logic                               is64Bit_o;
    logic [PidSize-1:0]                 instructionPid_o;
    logic [TidSize-1:0]                 instructionTid_o;
    logic [instructionCounterWidth-1:0] instructionMajId_o;

    modport master (
        output enable_i, instruction_i, instructionAddress_i, is64Bit_i,
               instructionPid_i, instructionTid_i, flush_i, stall_i,
        input  full_o, count_o, overflow_o, enable_o, instruction_o, instructionAddress_o,
               is64Bit_o, instructionPid_o, instructionTid_o, instructionMajId_o
    );

    modport slave (
        input  enable_i, instruction_i, instructionAddress_i, is64Bit_i,
               instructionPid_i, instructionTid_i, flush_i, stall_i,
        output full_o, count_o, overflow_o, enable_o, instruction_o, instructionAddress_o,
               is64Bit_o, instructionPid_o, instructionTid_o, instructionMajId_o
    );

endinterface

// File: rtl/fetch_queue_ram.sv
// Queue storage: register array with one synchronous write port and one
// asynchronous read port.
module fetch_queue_ram #(
    parameter int depth     = 8,
    parameter int width     = 32,
    parameter int addrWidth = $clog2(depth)
) (
    input  logic                 clock_i,
    input  logic                 writeEnable,
    input  logic [addrWidth-1:0] writeAddr,
    input  logic [width-1:0]     writeData,
    input  logic [addrWidth-1:0] readAddr,
    output logic [width-1:0]     readData
);

    logic [width-1:0] mem [depth];

    always_ff @(posedge clock_i) begin
        if (writeEnable) mem[writeAddr] <= writeData;
    end

    assign readData = mem[readAddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and DecodeUnit: stamps each accepted word with a
// major ID and presents words in order from a registered output stage.
module fetch_decode_queue
    import fetch_pkg::*;
#(
    parameter int addressWidth            = defAddressWidth,
    parameter int instructionWidth        = defInstructionWidth,
    parameter int PidSize                 = defPidSize,
    parameter int TidSize                 = defTidSize,
    parameter int instructionCounterWidth = defInstructionCounterWidth,
    parameter int queueDepth              = defQueueDepth
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    fetch_decode_queue_if.slave  bus
);

    localparam int ptrWidth   = $clog2(queueDepth);
    localparam int countWidth = ptrWidth + 1;
    localparam int entryW     = entryWidth(addressWidth, instructionWidth, PidSize,
                                           TidSize, instructionCounterWidth);

    logic [ptrWidth-1:0]                wrPtr, rdPtr;
    logic [countWidth-1:0]              count;
    logic [instructionCounterWidth-1:0] majIdCtr;
    logic                               overflow;
    logic                               enableReg;
    logic [instructionWidth-1:0]        instrReg;
    logic [addressWidth-1:0]            addrReg;
    logic                               is64Reg;
    logic [PidSize-1:0]                 pidReg;
    logic [TidSize-1:0]                 tidReg;
    logic [instructionCounterWidth-1:0] majIdReg;

    logic              full, empty, push, advance, drain;
    logic [entryW-1:0] wrData, rdData;

    assign full  = (count == countWidth'(queueDepth));
    assign empty = (count == '0);
    // full comes from the registered count, so a same-cycle advance never frees a slot.
    assign push    = bus.enable_i && !full && !bus.flush_i;
    assign advance = !empty && (!enableReg || !bus.stall_i);
    assign drain   = empty && enableReg && !bus.stall_i;

    assign wrData = {majIdCtr, bus.instructionTid_i, bus.instructionPid_i, bus.is64Bit_i,
                     bus.instructionAddress_i, bus.instruction_i};

    fetch_queue_ram #(
        .depth (queueDepth),
        .width (entryW)
    ) u_ram (
        .clock_i     (clock_i),
        .writeEnable (push),
        .writeAddr   (wrPtr),
        .writeData   (wrData),
        .readAddr    (rdPtr),
        .readData    (rdData)
    );

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (bus.flush_i) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push)    wrPtr <= wrPtr + ptrWidth'(1);
            if (advance) rdPtr <= rdPtr + ptrWidth'(1);
            if (push && !advance)      count <= count + countWidth'(1);
            else if (!push && advance) count <= count - countWidth'(1);
        end
    end

    // The ID counter is never rewound by flush so IDs stay unique.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            majIdCtr <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) majIdCtr <= majIdCtr + instructionCounterWidth'(1);
            if (bus.enable_i && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            enableReg <= 1'b0;
            instrReg  <= '0;
            addrReg   <= '0;
            is64Reg   <= 1'b0;
            pidReg    <= '0;
            tidReg    <= '0;
            majIdReg  <= '0;
        end else if (bus.flush_i) begin
            enableReg <= 1'b0;
        end else if (advance) begin
            enableReg <= 1'b1;
            {majIdReg, tidReg, pidReg, is64Reg, addrReg, instrReg} <= rdData;
        end else if (drain) begin
            enableReg <= 1'b0;
        end
    end

    assign bus.full_o               = full;
    assign bus.count_o              = count;
    assign bus.overflow_o           = overflow;
    assign bus.enable_o             = enableReg;
    assign bus.instruction_o        = instrReg;
    assign bus.instructionAddress_o = addrReg;
    assign bus.is64Bit_o            = is64Reg;
    assign bus.instructionPid_o     = pidReg;
    assign bus.instructionTid_o     = tidReg;
    assign bus.instructionMajId_o   = majIdReg;

endmodule
